// File: rtl/mix_columns_seq_pkg.sv
// rtl/mix_columns_seq_pkg.sv - shared AES mode codes, last-round constants and GF(2^8) helpers
package mix_columns_seq_pkg;

   localparam logic [1:0] MODE_AES128 = 2'h0;
   localparam logic [1:0] MODE_AES192 = 2'h2;
   localparam logic [1:0] MODE_AES256 = 2'h3;

   localparam logic [4:0] LAST_R128 = 5'h0a;
   localparam logic [4:0] LAST_R192 = 5'h0c;
   localparam logic [4:0] LAST_R256 = 5'h0e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // multiply by x in GF(2^8) with the AES polynomial
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul3(input logic [7:0] a);
      return xtime(a) ^ a;
   endfunction

   // true when this round skips MixColumns; unknown mode codes behave as AES-128
   function automatic logic is_last_round(input logic [4:0] round, input logic [1:0] mode);
      logic [4:0] last;
      case (mode)
         MODE_AES192: last = LAST_R192;
         MODE_AES256: last = LAST_R256;
         default:     last = LAST_R128;
      endcase
      return round == last;
   endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// rtl/mix_columns_seq_if.sv - input/output handshake bundle of the MixColumns stage
interface mix_columns_seq_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] S;
   logic [4:0]   round;
   logic [1:0]   mode;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] S_;
   logic         busy;

   modport master (
      output in_valid, S, round, mode, out_ready,
      input  in_ready, out_valid, S_, busy
   );

   modport slave (
      input  in_valid, S, round, mode, out_ready,
      output in_ready, out_valid, S_, busy
   );
endinterface

// File: rtl/mix_single_column.sv
// rtl/mix_single_column.sv - combinational forward MixColumns of one 32-bit column
module mix_single_column
   import mix_columns_seq_pkg::*;
(
   input  logic [31:0] col,
   output logic [31:0] mixed
);

   logic [7:0] a0, a1, a2, a3;

   assign a0 = col[31:24];
   assign a1 = col[23:16];
   assign a2 = col[15:8];
   assign a3 = col[7:0];

   assign mixed[31:24] = xtime(a0) ^ mul3(a1) ^ a2 ^ a3;
   assign mixed[23:16] = a0 ^ xtime(a1) ^ mul3(a2) ^ a3;
   assign mixed[15:8]  = a0 ^ a1 ^ xtime(a2) ^ mul3(a3);
   assign mixed[7:0]   = mul3(a0) ^ a1 ^ a2 ^ xtime(a3);

endmodule

// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - iterative forward MixColumns, one column per cycle, last-round bypass
module mix_columns_seq
   import mix_columns_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   mix_columns_seq_if.slave  bus
);

   state_t       state;
   logic [1:0]   col_cnt;
   logic [127:0] s_reg;
   logic [127:0] s_out;
   logic         out_valid_q;
   logic [31:0]  cur_col;
   logic [31:0]  mixed;

   assign bus.in_ready  = (state == ST_IDLE);
   assign bus.busy      = (state != ST_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.S_        = s_out;

   // select the column of the latched state that the shared mixer works on
   always_comb begin
      cur_col = s_reg[127:96];
      case (col_cnt)
         2'd0: cur_col = s_reg[127:96];
         2'd1: cur_col = s_reg[95:64];
         2'd2: cur_col = s_reg[63:32];
         2'd3: cur_col = s_reg[31:0];
         default: cur_col = s_reg[127:96];
      endcase
   end

   mix_single_column u_mix (
      .col   (cur_col),
      .mixed (mixed)
   );

   // control FSM: accept, mix four columns (or bypass), then hold the result until taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         col_cnt     <= 2'd0;
         s_reg       <= 128'h0;
         s_out       <= 128'h0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  s_reg <= bus.S;
                  if (is_last_round(bus.round, bus.mode)) begin
                     s_out <= bus.S;
                     state <= ST_DONE;
                  end else begin
                     state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               case (col_cnt)
                  2'd0: s_out[127:96] <= mixed;
                  2'd1: s_out[95:64]  <= mixed;
                  2'd2: s_out[63:32]  <= mixed;
                  default: s_out[31:0] <= mixed;
               endcase
               if (col_cnt == 2'd3) begin
                  col_cnt     <= 2'd0;
                  out_valid_q <= 1'b1;
                  state       <= ST_DONE;
               end else begin
                  col_cnt <= col_cnt + 2'd1;
               end
            end
            ST_DONE: begin
               // the bypass path arrives here with out_valid still low and raises it one edge later
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               state       <= ST_IDLE;
               col_cnt     <= 2'd0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb/tb_mix_columns_seq.sv - self-checking bench for mix_columns_seq
module tb_mix_columns_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   mix_columns_seq_if bus ();

   mix_columns_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [127:0] ref_mix(input logic [127:0] s);
      logic [7:0]   base [4];
      logic [7:0]   a [4];
      logic [7:0]   b;
      logic [127:0] r;
      base[0] = 8'd2; base[1] = 8'd3; base[2] = 8'd1; base[3] = 8'd1;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 4; i++) a[i] = s[127 - 32*c - 8*i -: 8];
         for (int row = 0; row < 4; row++) begin
            b = 8'h00;
            for (int k = 0; k < 4; k++) b = b ^ gmul(a[k], base[(k - row + 4) % 4]);
            r[127 - 32*c - 8*row -: 8] = b;
         end
      end
      return r;
   endfunction

   function automatic bit ref_bypass(input logic [4:0] round, input logic [1:0] mode);
      int last;
      last = (mode == 2'h3) ? 14 : (mode == 2'h2) ? 12 : 10;
      return int'(round) == last;
   endfunction

   function automatic logic [127:0] ref_out(input logic [127:0] s, input logic [4:0] round,
                                            input logic [1:0] mode);
      return ref_bypass(round, mode) ? s : ref_mix(s);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present a state and hold it until the accept edge; ok=0 if never accepted
   task automatic do_accept(input logic [127:0] s, input logic [4:0] r, input logic [1:0] m,
                            output bit ok);
      ok = 1'b0;
      bus.S = s;
      bus.round = r;
      bus.mode = m;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (bus.in_ready) begin
            ok = 1'b1;
            tick();
            break;
         end
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   // edges after the accept edge until out_valid is seen; -1 on timeout
   task automatic wait_valid(output int lat);
      lat = -1;
      for (int i = 0; i <= 20; i++) begin
         if (bus.out_valid) begin
            lat = i;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.S_ !== 128'h0) begin
         bad++;
         $display("FAIL reset_in: out_valid=%b in_ready=%b busy=%b S_=%h want 0 1 0 0",
                  bus.out_valid, bus.in_ready, bus.busy, bus.S_);
      end
      rst = 1'b0;
      tick();
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.S_ !== 128'h0) begin
         bad++;
         $display("FAIL reset_out: out_valid=%b in_ready=%b busy=%b S_=%h want 0 1 0 0",
                  bus.out_valid, bus.in_ready, bus.busy, bus.S_);
      end
   endtask

   task automatic test_fips();
      bit ok;
      int lat;
      logic [127:0] s;
      s = 128'hdb135345_f20a225c_01010101_2d26314c;
      bus.out_ready = 1'b1;
      do_accept(s, 5'd1, 2'd0, ok);
      total++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         bad++;
         $display("FAIL fips_busy: busy=%b in_ready=%b want 1 0", bus.busy, bus.in_ready);
      end
      wait_valid(lat);
      total++;
      if (!ok || lat != 4) begin
         bad++;
         $display("FAIL fips_latency: accepted=%0d latency=%0d want 1 4", ok, lat);
      end
      total++;
      if (bus.S_ !== 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8) begin
         bad++;
         $display("FAIL fips_value: got %h want 8e4da1bc9fdc589d010101014d7ebdf8", bus.S_);
      end
      tick();
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL fips_release: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_bypass();
      bit ok;
      int lat;
      logic [127:0] s;
      s = 128'h00112233_44556677_8899aabb_ccddeeff;
      bus.out_ready = 1'b1;
      do_accept(s, 5'h0e, 2'h3, ok);
      wait_valid(lat);
      total++;
      if (!ok || lat != 1 || bus.S_ !== s) begin
         bad++;
         $display("FAIL bypass_256: accepted=%0d latency=%0d S_=%h want 1 1 %h", ok, lat, bus.S_, s);
      end
      tick();
      do_accept(s, 5'h0d, 2'h3, ok);
      wait_valid(lat);
      total++;
      if (!ok || lat != 4 || bus.S_ !== ref_mix(s)) begin
         bad++;
         $display("FAIL mix_256_r13: accepted=%0d latency=%0d S_=%h want 1 4 %h", ok, lat, bus.S_, ref_mix(s));
      end
      tick();
   endtask

   task automatic test_backpressure();
      bit ok;
      int lat;
      logic [127:0] s;
      logic [127:0] held;
      s = 128'hdb135345_f20a225c_01010101_2d26314c;
      bus.out_ready = 1'b0;
      do_accept(s, 5'd3, 2'd0, ok);
      wait_valid(lat);
      held = bus.S_;
      total++;
      if (!ok || lat != 4 || held !== ref_mix(s)) begin
         bad++;
         $display("FAIL bp_first: accepted=%0d latency=%0d S_=%h want 1 4 %h", ok, lat, held, ref_mix(s));
      end
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            bus.in_valid = 1'b1;
            bus.S = {$urandom, $urandom, $urandom, $urandom};
            bus.round = 5'd1;
         end
         tick();
         bus.in_valid = 1'b0;
         total++;
         if (bus.out_valid !== 1'b1 || bus.S_ !== held || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b S_=%h want 1 0 %h",
                     i, bus.out_valid, bus.in_ready, bus.S_, held);
         end
      end
      bus.out_ready = 1'b1;
      tick();
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
      end
      tick();
      tick();
      total++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_ignored_pulse: busy=%b out_valid=%b want 0 0", bus.busy, bus.out_valid);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int lat;
      bus.out_ready = 1'b1;
      do_accept(128'hdb135345_f20a225c_01010101_2d26314c, 5'd2, 2'd0, ok);
      tick();
      tick();
      rst = 1'b1;
      #1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.S_ !== 128'h0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: out_valid=%b S_=%h in_ready=%b busy=%b want 0 0 1 0",
                  bus.out_valid, bus.S_, bus.in_ready, bus.busy);
      end
      tick();
      rst = 1'b0;
      tick();
      do_accept({4{32'hd4d4d4d5}}, 5'd2, 2'd0, ok);
      wait_valid(lat);
      total++;
      if (!ok || lat != 4 || bus.S_ !== {4{32'hd5d5d7d6}}) begin
         bad++;
         $display("FAIL reset_recover: accepted=%0d latency=%0d S_=%h want 1 4 %h",
                  ok, lat, bus.S_, {4{32'hd5d5d7d6}});
      end
      tick();
   endtask

   task automatic test_back_to_back(input bit bypass);
      logic [127:0] ins [3];
      logic [127:0] exp_q [$];
      logic [127:0] cap;
      logic [4:0]   r;
      int idx;
      int got;
      int last_cyc;
      int gap;
      bit acc;
      bit fire;
      r = bypass ? 5'h0c : 5'h07;
      for (int i = 0; i < 3; i++) ins[i] = {$urandom, $urandom, $urandom, $urandom};
      gap = bypass ? 3 : 6;
      idx = 0;
      got = 0;
      last_cyc = -1;
      bus.out_ready = 1'b1;
      bus.mode = 2'h2;
      bus.round = r;
      bus.S = ins[0];
      bus.in_valid = 1'b1;
      for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
         acc = bus.in_valid && bus.in_ready;
         fire = bus.out_valid && bus.out_ready;
         cap = bus.S_;
         tick();
         if (acc) begin
            exp_q.push_back(ref_out(ins[idx], r, 2'h2));
            idx++;
            if (idx < 3) bus.S = ins[idx];
            else bus.in_valid = 1'b0;
         end
         if (fire) begin
            total++;
            if (exp_q.size() == 0 || cap !== exp_q[0]) begin
               bad++;
               $display("FAIL b2b_value[%0d]: got %h want %h", got, cap,
                        (exp_q.size() == 0) ? 128'h0 : exp_q[0]);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (last_cyc >= 0) begin
               total++;
               if (cyc - last_cyc != gap) begin
                  bad++;
                  $display("FAIL b2b_spacing[%0d]: got %0d want %0d", got, cyc - last_cyc, gap);
               end
            end
            last_cyc = cyc;
            got++;
         end
      end
      bus.in_valid = 1'b0;
      total++;
      if (got != 3 || idx != 3) begin
         bad++;
         $display("FAIL b2b_count: results=%0d accepts=%0d want 3 3", got, idx);
      end
      tick();
   endtask

   task automatic test_mode_default();
      bit ok;
      int lat;
      logic [127:0] s;
      s = {$urandom, $urandom, $urandom, $urandom};
      bus.out_ready = 1'b1;
      do_accept(s, 5'h0a, 2'h1, ok);
      wait_valid(lat);
      total++;
      if (!ok || lat != 1 || bus.S_ !== s) begin
         bad++;
         $display("FAIL mode1_bypass: accepted=%0d latency=%0d S_=%h want 1 1 %h", ok, lat, bus.S_, s);
      end
      tick();
      do_accept(s, 5'h0c, 2'h1, ok);
      wait_valid(lat);
      total++;
      if (!ok || lat != 4 || bus.S_ !== ref_mix(s)) begin
         bad++;
         $display("FAIL mode1_mix: accepted=%0d latency=%0d S_=%h want 1 4 %h", ok, lat, bus.S_, ref_mix(s));
      end
      tick();
   endtask

   task automatic test_random();
      bit ok;
      int lat;
      logic [127:0] s;
      logic [4:0]   r;
      logic [1:0]   m;
      bus.out_ready = 1'b1;
      for (int n = 0; n < 24; n++) begin
         s = {$urandom, $urandom, $urandom, $urandom};
         m = 2'($urandom_range(0, 3));
         r = (n % 3 == 0) ? 5'($urandom_range(10, 14)) : 5'($urandom_range(0, 31));
         do_accept(s, r, m, ok);
         wait_valid(lat);
         total++;
         if (!ok || lat != (ref_bypass(r, m) ? 1 : 4) || bus.S_ !== ref_out(s, r, m)) begin
            bad++;
            $display("FAIL random[%0d]: r=%h m=%h accepted=%0d latency=%0d S_=%h want %h",
                     n, r, m, ok, lat, bus.S_, ref_out(s, r, m));
         end
         tick();
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.S = '0;
      bus.round = '0;
      bus.mode = '0;
      bus.out_ready = 1'b1;
      tick();
      test_reset();
      test_fips();
      test_bypass();
      test_backpressure();
      test_reset_mid();
      test_back_to_back(1'b0);
      test_back_to_back(1'b1);
      test_mode_default();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
